// File: rtl/tx_ethernet_if.sv
// Host-side request and payload handshake of the GMII frame transmitter.
interface tx_ethernet_if;
    logic [47:0] mac_addr;
    logic [47:0] tx_dst_mac;
    logic [15:0] tx_ethertype;
    logic [10:0] tx_len;
    logic        tx_start;
    logic        tx_payload_rd;
    logic [7:0]  tx_payload;
    logic        tx_busy;
    logic        tx_done_irq;

    modport master (
        output mac_addr, tx_dst_mac, tx_ethertype, tx_len, tx_start, tx_payload,
        input  tx_payload_rd, tx_busy, tx_done_irq
    );

    modport slave (
        input  mac_addr, tx_dst_mac, tx_ethertype, tx_len, tx_start, tx_payload,
        output tx_payload_rd, tx_busy, tx_done_irq
    );
endinterface

// File: rtl/tx_ethernet.sv
// GMII Ethernet II transmitter: preamble, SFD, MAC header, payload, zero pad, CRC-32 FCS, IFG.
// States: IDLE | PRE | SFD | DST | SRC | TYPE | PAY | PAD | FCS | IFG; each names the octet registered onto TXD at the next edge.
module tx_ethernet #(
    parameter int          OCT         = 8,
    parameter logic [7:0]  PRE         = 8'b10101010,
    parameter logic [7:0]  SFD         = 8'b10101011,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG         = 12
) (
    input  logic           TX_CLK,
    input  logic           rst,
    tx_ethernet_if.slave   host,
    output logic           TX_EN,
    output logic [OCT-1:0] TXD,
    output logic           TX_ER
);

    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_C = 11'(IFG - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t         state, state_nxt;
    logic [10:0]    cnt, cnt_nxt;
    logic           tc;
    logic [47:0]    dst_q, src_q;
    logic [15:0]    type_q;
    logic [10:0]    len_q, len_clamp;
    logic [31:0]    crc, crc_nxt;
    logic [OCT-1:0] octet;
    logic           en_nxt, busy_nxt, done_nxt, crc_en, rd, busy, done;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [OCT-1:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < OCT; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign tc        = (cnt == 11'd0);
    assign len_clamp = (host.tx_len > MAX_L) ? MAX_L : host.tx_len;
    assign crc_nxt   = crc_step(crc, octet);

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 11'd0;
            dst_q  <= 48'h0;
            src_q  <= 48'h0;
            type_q <= 16'h0;
            len_q  <= 11'd0;
            crc    <= 32'hFFFFFFFF;
            TXD    <= '0;
            TX_EN  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            TXD   <= octet;
            TX_EN <= en_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (state == S_IDLE && host.tx_start) begin
                dst_q  <= host.tx_dst_mac;
                src_q  <= host.mac_addr;
                type_q <= host.tx_ethertype;
                len_q  <= len_clamp;
                crc    <= 32'hFFFFFFFF;
            end else if (crc_en) begin
                crc <= crc_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tc ? cnt : cnt - 11'd1;
        case (state)
            S_IDLE: if (host.tx_start) begin state_nxt = S_PRE; cnt_nxt = 11'd5; end
            S_PRE:  if (tc) state_nxt = S_SFD;
            S_SFD:  begin state_nxt = S_DST; cnt_nxt = 11'd5; end
            S_DST:  if (tc) begin state_nxt = S_SRC; cnt_nxt = 11'd5; end
            S_SRC:  if (tc) begin state_nxt = S_TYPE; cnt_nxt = 11'd1; end
            S_TYPE: if (tc) begin
                if (len_q == 11'd0) begin
                    state_nxt = S_PAD;
                    cnt_nxt   = MIN_L - 11'd1;
                end else begin
                    state_nxt = S_PAY;
                    cnt_nxt   = len_q - 11'd1;
                end
            end
            S_PAY:  if (tc) begin
                if (len_q < MIN_L) begin
                    state_nxt = S_PAD;
                    cnt_nxt   = MIN_L - 11'd1 - len_q;
                end else begin
                    state_nxt = S_FCS;
                    cnt_nxt   = 11'd3;
                end
            end
            S_PAD:  if (tc) begin state_nxt = S_FCS; cnt_nxt = 11'd3; end
            S_FCS:  if (tc) begin state_nxt = S_IFG; cnt_nxt = IFG_C; end
            S_IFG:  if (tc) state_nxt = S_IDLE;
            default: begin state_nxt = S_IDLE; cnt_nxt = 11'd0; end
        endcase
    end

    always_comb begin
        octet    = '0;
        en_nxt   = 1'b0;
        crc_en   = 1'b0;
        rd       = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = busy;
        case (state)
            S_IDLE: if (host.tx_start) begin
                octet    = PRE;
                en_nxt   = 1'b1;
                busy_nxt = 1'b1;
            end
            S_PRE:  begin octet = PRE; en_nxt = 1'b1; end
            S_SFD:  begin octet = SFD; en_nxt = 1'b1; end
            S_DST:  begin octet = dst_q[{cnt[2:0], 3'b000} +: 8]; en_nxt = 1'b1; crc_en = 1'b1; end
            S_SRC:  begin octet = src_q[{cnt[2:0], 3'b000} +: 8]; en_nxt = 1'b1; crc_en = 1'b1; end
            S_TYPE: begin octet = type_q[{cnt[0], 3'b000} +: 8]; en_nxt = 1'b1; crc_en = 1'b1; end
            S_PAY:  begin octet = host.tx_payload; rd = 1'b1; en_nxt = 1'b1; crc_en = 1'b1; end
            S_PAD:  begin en_nxt = 1'b1; crc_en = 1'b1; end
            // FCS goes out low byte first from the CRC frozen after the last data octet
            S_FCS:  begin octet = ~crc[{~cnt[1:0], 3'b000} +: 8]; en_nxt = 1'b1; end
            S_IFG:  begin
                done_nxt = (cnt == IFG_C);
                if (tc) busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    assign host.tx_payload_rd = rd;
    assign host.tx_busy       = busy;
    assign host.tx_done_irq   = done;
    assign TX_ER              = 1'b0;

endmodule

// File: tb/tb_tx_ethernet.sv
// Directed bench for tx_ethernet: frame layout, lengths, padding, clamping, IFG, mid-frame reset.
module tb_tx_ethernet;
    logic       TX_CLK = 1'b0;
    logic       rst;
    logic       TX_EN;
    logic [7:0] TXD;
    logic       TX_ER;

    tx_ethernet_if bus();

    tx_ethernet dut (
        .TX_CLK (TX_CLK),
        .rst    (rst),
        .host   (bus),
        .TX_EN  (TX_EN),
        .TXD    (TXD),
        .TX_ER  (TX_ER)
    );

    always #5 TX_CLK = ~TX_CLK;

    int total = 0;
    int bad   = 0;

    logic [7:0] cap[$];
    int         rd_cnt, done_cnt, low_run, last_gap, pidx, hi_seen;
    bit         er_seen, start_acc;
    logic       s_en, s_done, s_busy, s_rd;
    logic [7:0] s_txd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw_crc_residue();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < cap.size(); i++) begin
            c = c ^ {24'h0, cap[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // one clock: sample at the falling edge, then refresh the show-ahead payload after the rising edge
    task automatic cycle();
        @(negedge TX_CLK);
        s_en   = TX_EN;
        s_txd  = TXD;
        s_done = bus.tx_done_irq;
        s_busy = bus.tx_busy;
        s_rd   = bus.tx_payload_rd;
        if (TX_ER) er_seen = 1'b1;
        if (s_rd) rd_cnt++;
        if (s_done) done_cnt++;
        if (s_en) begin
            hi_seen++;
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        start_acc = bus.tx_start && !s_busy && !rst;
        @(posedge TX_CLK);
        #1;
        if (start_acc) pidx = 0;
        else if (s_rd) pidx++;
        bus.tx_payload = pidx[7:0];
    endtask

    task automatic wait_frame(input string tag, input int len, input bit drop_start,
                              input logic [47:0] dst, input logic [47:0] mac, input logic [15:0] typ);
        int guard, n, exp_len, nbad;
        logic [7:0]  eb;
        logic [47:0] t;
        cap.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        guard    = 0;
        do begin
            cycle();
            guard++;
        end while (!s_en && guard < 100);
        check({tag, "_start"}, s_en, 1'b1);
        if (drop_start) bus.tx_start = 1'b0;
        check({tag, "_busy"}, s_busy, 1'b1);
        n = 0;
        while (s_en && n < 2000) begin
            cap.push_back(s_txd);
            n++;
            cycle();
        end
        exp_len = 26 + ((len > 46) ? len : 46);
        check({tag, "_en_len"}, n, exp_len);
        check({tag, "_done_at_fall"}, s_done, 1'b1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_rd_cnt"}, rd_cnt, len);
        if (n == exp_len) begin
            nbad = 0;
            for (int i = 0; i < exp_len - 4; i++) begin
                if (i < 7)       eb = 8'hAA;
                else if (i == 7) eb = 8'hAB;
                else if (i < 14) begin t = dst >> (8 * (13 - i)); eb = t[7:0]; end
                else if (i < 20) begin t = mac >> (8 * (19 - i)); eb = t[7:0]; end
                else if (i == 20) eb = typ[15:8];
                else if (i == 21) eb = typ[7:0];
                else if (i < 22 + len) eb = 8'((i - 22) & 255);
                else eb = 8'h00;
                if (cap[i] !== eb) nbad++;
            end
            check({tag, "_bytes_bad"}, nbad, 0);
            check({tag, "_crc_residue"}, sw_crc_residue(), 32'hDEBB20E3);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.tx_start     = 1'b0;
        bus.tx_len       = 11'd0;
        bus.mac_addr     = 48'h020000000001;
        bus.tx_dst_mac   = 48'hFFFFFFFFFFFF;
        bus.tx_ethertype = 16'h0800;
        bus.tx_payload   = 8'h00;
        pidx = 0; low_run = 0; last_gap = 0; hi_seen = 0;
        rd_cnt = 0; done_cnt = 0; er_seen = 1'b0;

        repeat (3) cycle();
        check("rst_en", s_en, 1'b0);
        check("rst_txd", s_txd, 8'h00);
        check("rst_busy", s_busy, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("rst_rd", s_rd, 1'b0);
        rst = 1'b0;
        cycle();
        check("idle_en", s_en, 1'b0);

        // frame 1: broadcast, 64-byte counting payload
        bus.tx_len = 11'd64;
        bus.tx_start = 1'b1;
        wait_frame("t1", 64, 1'b1, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
        repeat (10) cycle();
        check("t1_ifg11_busy", s_busy, 1'b1);
        check("t1_ifg11_en", s_en, 1'b0);
        cycle();
        check("t1_ifg12_busy", s_busy, 1'b0);
        check("t1_ifg_done_once", done_cnt, 1);

        // short payload: 10 reads, 36 pad octets
        repeat (5) cycle();
        bus.tx_dst_mac   = 48'h112233445566;
        bus.mac_addr     = 48'hA0B0C0D0E0F0;
        bus.tx_ethertype = 16'h86DD;
        bus.tx_len = 11'd10;
        bus.tx_start = 1'b1;
        wait_frame("t2", 10, 1'b1, 48'h112233445566, 48'hA0B0C0D0E0F0, 16'h86DD);

        // empty payload: all pad
        repeat (15) cycle();
        bus.tx_len = 11'd0;
        bus.tx_start = 1'b1;
        wait_frame("t3", 0, 1'b1, 48'h112233445566, 48'hA0B0C0D0E0F0, 16'h86DD);

        // oversize request clamps to 1500
        repeat (15) cycle();
        bus.tx_dst_mac   = 48'hFFFFFFFFFFFF;
        bus.mac_addr     = 48'h020000000001;
        bus.tx_ethertype = 16'h0800;
        bus.tx_len = 11'd2000;
        bus.tx_start = 1'b1;
        wait_frame("t4", 1500, 1'b1, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);

        // start held across a frame: exactly one follow-on frame after a 12-cycle gap
        repeat (15) cycle();
        bus.tx_len = 11'd64;
        bus.tx_start = 1'b1;
        wait_frame("t5a", 64, 1'b0, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
        wait_frame("t5b", 64, 1'b1, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
        check("t5_gap", last_gap, 12);
        hi_seen = 0;
        repeat (30) cycle();
        check("t5_no_third", hi_seen, 0);

        // reset during the source address field
        bus.tx_start = 1'b1;
        cycle();
        bus.tx_start = 1'b0;
        repeat (16) cycle();
        check("t6_mid_en", s_en, 1'b1);
        done_cnt = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("t6_abort_en", s_en, 1'b0);
        check("t6_abort_busy", s_busy, 1'b0);
        check("t6_abort_txd", s_txd, 8'h00);
        check("t6_no_done", done_cnt, 0);
        bus.tx_start = 1'b1;
        wait_frame("t6", 64, 1'b1, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);

        check("tx_er_low", er_seen, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_ethernet.md
Name: tx_ethernet

Overview:
GMII Ethernet II frame transmitter, the transmit-side counterpart of rx_ethernet. It sits between the UDP/IPv4 transmit stages (or CPU-filled TX memory) and the GMII TXD/TX_EN/TX_ER pins of top. On a start pulse it emits the preamble, SFD, MAC header, the payload bytes pulled from upstream, zero padding up to the minimum frame size, and the CRC-32 FCS. It then enforces the inter-frame gap before accepting the next frame.

Parameters:
OCT, 8, bits per octet
PRE, 8'b10101010, preamble octet, driven on TXD verbatim (same encoding rx_ethernet matches)
SFD, 8'b10101011, start-of-frame delimiter octet, driven on TXD verbatim
MIN_PAYLOAD, 46, minimum payload octets; shorter payloads are zero-padded
MAX_PAYLOAD, 1500, maximum payload octets; larger tx_len is clamped
IFG, 12, inter-frame gap in TX_CLK cycles

Ports:
TX_CLK  input  1  transmit clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
mac_addr  input  48  own MAC address, used as the source address; [47:40] is sent first
tx_dst_mac  input  48  destination MAC; [47:40] is sent first
tx_ethertype  input  16  EtherType (e.g. 16'h0800); [15:8] is sent first
tx_len  input  11  payload length in octets
tx_start  input  1  frame request; sampled only in IDLE
tx_payload_rd  output  1  payload read strobe; the octet is consumed in the same cycle
tx_payload  input  8  payload octet, show-ahead; must be valid whenever tx_payload_rd=1
tx_busy  output  1  high from start acceptance until the end of the IFG
tx_done_irq  output  1  one-cycle pulse at end of frame
TX_EN  output  1  GMII transmit enable
TXD  output  8  GMII transmit data
TX_ER  output  1  GMII transmit error; constant 0

Behaviour:
- Reset (synchronous, takes effect on the next edge): state=IDLE, TX_EN=0, TXD=8'h00, TX_ER=0, tx_payload_rd=0, tx_busy=0, tx_done_irq=0, CRC=32'hFFFFFFFF, counters=0.
- All outputs are registered, except tx_payload_rd, which is decoded from state/counter.
- IDLE: if tx_start=1 at edge N, latch tx_dst_mac, mac_addr, tx_ethertype and min(tx_len, MAX_PAYLOAD) at edge N.
  - tx_busy=1 and TX_EN=1 from cycle N+1, with the first PRE on TXD.
  - tx_start in any other state is ignored, not queued.
- PREAMBLE: 7 cycles of PRE.
- SFD: 1 cycle of SFD.
- DST: 6 cycles. SRC: 6 cycles. TYPE: 2 cycles.
- PAYLOAD: L cycles, where L = the latched length.
  - tx_payload_rd is high exactly in the cycles that precede TXD showing the octet.
  - The octet is registered onto TXD the next cycle, so the TXD stream has no gaps.
  - L=0 skips this state.
- PAD: max(0, MIN_PAYLOAD-L) cycles of 8'h00.
- FCS: 4 cycles. TXD = ~CRC[7:0], ~CRC[15:8], ~CRC[23:16], ~CRC[31:24], using the CRC value frozen after the last pad/payload octet.
- CRC-32 definition:
  - reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, LSB-first per octet;
  - covers DST through PAD inclusive; the preamble and SFD are excluded;
  - updated combinationally per octet as it is registered onto TXD.
- End of frame: TX_EN=1 for exactly 8+14+max(L,46)+4 consecutive cycles.
  - In the cycle after the last FCS octet: TX_EN=0, TXD=8'h00, tx_done_irq=1 for one cycle.
- IFG state: IFG cycles with TX_EN=0, counted from the first cycle of TX_EN=0.
  - Then tx_busy=0 and the state returns to IDLE.
  - Back-to-back frames are therefore separated by exactly IFG low cycles of TX_EN.
- Counter widths:
  - the octet counter is 11 bits;
  - the comparison against MAX_PAYLOAD clamps before latching, so there is no wrap.
- Reset mid-frame: the frame aborts on the next edge (TX_EN=0), no tx_done_irq, no IFG; IDLE after reset releases.
- rst and tx_start in the same cycle: reset wins.

Test Plan:
1. Reset, then tx_start with L=64, dst=48'hFFFFFFFFFFFF, mac=48'h020000000001, type=16'h0800, payload=0x00..0x3F -> TX_EN high for 90 cycles; TXD shows 7×8'hAA, 8'hAB, FF×6, 02 00 00 00 00 01, 08 00, payload in order. A software CRC over DST..FCS gives residue 32'hDEBB20E3; tx_done_irq pulses once the cycle TX_EN falls.
2. L=10 -> 10 payload reads (tx_payload_rd high exactly 10 cycles), 36 zero pad octets, TX_EN high 72 cycles, FCS valid per residue check.
3. L=0 -> no tx_payload_rd, 46 pad octets, TX_EN high 72 cycles.
4. tx_len=2000 -> clamped: exactly 1500 reads, TX_EN high 1526 cycles.
5. Second tx_start held high continuously after frame 1 -> TX_EN low for exactly 12 cycles between frames. Starts asserted while tx_busy=1 are ignored (only one extra frame per IDLE entry).
6. rst pulsed during the SRC field of an L=64 frame -> TX_EN=0 next cycle, no tx_done_irq, tx_busy=0. A new tx_start one cycle after rst falls produces a complete, CRC-correct frame.
